// File: rtl/tmds_period_sequencer.sv
// TMDS channel sequencer: delays each pixel sample by 11 cycles and frames video
// periods with control, preamble and guard-band words around DC-balanced data.

module tm_choice (
  input  logic [7:0] d,
  output logic [8:0] qm
);
  logic [3:0] n1;
  logic       use_xnor;

  assign n1       = 4'($countones(d));
  assign use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
  assign qm[8]    = ~use_xnor;

  // An XNOR chain is the XOR prefix parity with every odd bit inverted.
  for (genvar i = 0; i < 8; i++) begin : g_qm
    assign qm[i] = (^d[i:0]) ^ (use_xnor & (i % 2 == 1));
  end
endmodule

module tmds_period_sequencer #(
  parameter int CHANNEL = 0
) (
  input  logic       pixel_clk_in,
  input  logic       rst_n_in,
  input  logic [7:0] data_in,
  input  logic       de_in,
  input  logic [1:0] ctrl_in,
  output logic [9:0] tmds_out,
  output logic       video_active_out,
  output logic       err_short_blank_out
);
  localparam int         DEPTH      = 10;
  localparam logic [9:0] CTRL00     = 10'b1101010100;
  localparam logic [9:0] GUARD_CODE = (CHANNEL == 1) ? 10'b0100110011 : 10'b1011001100;

  typedef enum logic [1:0] {ST_CTRL, ST_PREAMBLE, ST_GUARD, ST_VIDEO} state_t;
  typedef struct packed {logic [7:0] data; logic de; logic [1:0] ctrl;} sample_t;
  typedef struct packed {logic [8:0] qm; logic de; logic [1:0] ctrl;} coded_t;

  sample_t           dl_q [DEPTH];
  sample_t           dl_d [DEPTH];
  coded_t            coded_q, coded_d;
  state_t            state_q, state_d;
  logic [2:0]        phase_q, phase_d;
  logic signed [5:0] cnt_q, cnt_d;
  logic [9:0]        tmds_q, tmds_d;
  logic              va_q, va_d, err_q, err_d;

  logic [8:0]        qm_tap;
  logic              rise, line_blank;
  logic [1:0]        pre_ctrl;
  logic [3:0]        n1, n0;
  logic signed [5:0] diff, enc_cnt;
  logic [9:0]        enc_word;

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  tm_choice u_tm_choice (
    .d  (dl_q[DEPTH-1].data),
    .qm (qm_tap)
  );

  always_comb begin
    dl_d[0] = '{data: data_in, de: de_in, ctrl: ctrl_in};
    for (int i = 1; i < DEPTH; i++) dl_d[i] = dl_q[i-1];
    coded_d = '{qm: qm_tap, de: dl_q[DEPTH-1].de, ctrl: dl_q[DEPTH-1].ctrl};
  end

  // A preamble may only start if every word it will overwrite is blanking.
  always_comb begin
    line_blank = 1'b1;
    for (int i = 0; i < DEPTH; i++) if (dl_q[i].de) line_blank = 1'b0;
    rise     = de_in & ~dl_q[0].de;
    pre_ctrl = (CHANNEL == 1) ? 2'b01 : (CHANNEL == 2) ? 2'b00 : coded_q.ctrl;
  end

  always_comb begin
    n1   = 4'($countones(coded_q.qm[7:0]));
    n0   = 4'd8 - n1;
    diff = $signed({2'b00, n1}) - $signed({2'b00, n0});
    if ((cnt_q == 6'sd0) || (n1 == n0)) begin
      enc_word = {~coded_q.qm[8], coded_q.qm[8],
                  coded_q.qm[8] ? coded_q.qm[7:0] : ~coded_q.qm[7:0]};
      enc_cnt  = cnt_q + (coded_q.qm[8] ? diff : -diff);
    end else if ((!cnt_q[5] && (n1 > n0)) || (cnt_q[5] && (n0 > n1))) begin
      enc_word = {1'b1, coded_q.qm[8], ~coded_q.qm[7:0]};
      enc_cnt  = cnt_q + (coded_q.qm[8] ? 6'sd2 : 6'sd0) - diff;
    end else begin
      enc_word = {1'b0, coded_q.qm[8], coded_q.qm[7:0]};
      enc_cnt  = cnt_q + diff - (coded_q.qm[8] ? 6'sd0 : 6'sd2);
    end
  end

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = 6'sd0;
    tmds_d  = ctrl_code(coded_q.ctrl);
    va_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_CTRL: begin
        if (coded_q.de) begin
          tmds_d  = enc_word;
          cnt_d   = enc_cnt;
          va_d    = 1'b1;
          err_d   = 1'b1;
          state_d = ST_VIDEO;
        end
        if (rise && line_blank) begin
          state_d = ST_PREAMBLE;
          phase_d = 3'd0;
        end
      end
      ST_PREAMBLE: begin
        tmds_d  = ctrl_code(pre_ctrl);
        phase_d = phase_q + 3'd1;
        if (phase_q == 3'd7) begin
          state_d = ST_GUARD;
          phase_d = 3'd0;
        end
      end
      ST_GUARD: begin
        tmds_d  = GUARD_CODE;
        phase_d = phase_q + 3'd1;
        if (phase_q == 3'd1) begin
          state_d = ST_VIDEO;
          phase_d = 3'd0;
        end
      end
      ST_VIDEO: begin
        if (coded_q.de) begin
          tmds_d = enc_word;
          cnt_d  = enc_cnt;
          va_d   = 1'b1;
        end else begin
          state_d = ST_CTRL;
        end
      end
      default: state_d = ST_CTRL;
    endcase
  end

  // NOTE: the delay line is reset like any other flop; a stale de=1 left in it
  // would block the preamble of the first video period after reset.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) dl_q[i] <= '0;
      coded_q <= '0;
      state_q <= ST_CTRL;
      phase_q <= 3'd0;
      cnt_q   <= 6'sd0;
      tmds_q  <= CTRL00;
      va_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      dl_q    <= dl_d;
      coded_q <= coded_d;
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      tmds_q  <= tmds_d;
      va_q    <= va_d;
      err_q   <= err_d;
    end
  end

  assign tmds_out            = tmds_q;
  assign video_active_out    = va_q;
  assign err_short_blank_out = err_q;
endmodule

// File: doc/tmds_period_sequencer.md
TMDS_PERIOD_SEQUENCER -- requirements
Module: tmds_period_sequencer

Interface
REQ-001 Parameter: CHANNEL, default 0, selects TMDS channel 0/1/2 (preamble and guard-band codes).
REQ-002 pixel_clk_in  input  1  pixel clock; all state changes on its rising edge.
REQ-003 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-004 data_in  input  8  pixel byte, sampled every cycle.
REQ-005 de_in  input  1  data enable; 1 = active video pixel.
REQ-006 ctrl_in  input  2  control bits {c1,c0} for blanking periods.
REQ-007 tmds_out  output  10  registered encoded TMDS word.
REQ-008 video_active_out  output  1  1 while tmds_out carries a video-data word.
REQ-009 err_short_blank_out  output  1  one-cycle pulse when a video period starts without preamble and guard band.

Function
REQ-010 Input path SHALL be a 10-stage delay line of {data_in, de_in, ctrl_in}; tmds_out SHALL be registered after the last stage, giving a fixed 11-cycle latency for every input sample.
REQ-011 Stage-1 coding SHALL reuse the existing tm_choice module on the delay-line tap to produce qm[8:0].
REQ-012 FSM states: CTRL, PREAMBLE, GUARD, VIDEO; reset state CTRL.
REQ-013 Rising edge is defined as de_in=1 sampled at edge k and de_in=0 sampled at edge k-1.
REQ-014 CTRL -> PREAMBLE on a de_in rising edge when all 10 delay-line stages hold de=0; tmds_out after edges k+1..k+8 SHALL be preamble codes.
REQ-015 PREAMBLE -> GUARD after 8 cycles; tmds_out after edges k+9 and k+10 SHALL be guard-band codes; GUARD -> VIDEO after 2 cycles, first pixel at edge k+11.
REQ-016 VIDEO -> CTRL when delayed de is 0; that sample is output as a control code.
REQ-017 Rising edge with any delay-line de=1 SHALL be ignored by the FSM; the delayed pixel is then encoded as data from CTRL (-> VIDEO directly), with err_short_blank_out pulsed on the cycle the first such data word is registered.
REQ-018 Preamble ctrl: CHANNEL 1 uses 2'b01, CHANNEL 2 uses 2'b00, CHANNEL 0 uses delayed ctrl_in.
REQ-019 Guard-band code: CHANNEL 0 and 2 = 10'b1011001100, CHANNEL 1 = 10'b0100110011.
REQ-020 Control codes: 00->1101010100, 01->0010101011, 10->0101010100, 11->1010101011.
REQ-021 Disparity cnt SHALL be 6-bit signed, updated only on data words, forced to 0 on every control/preamble/guard word.
REQ-022 With N1/N0 = ones/zeros in qm[7:0]: if cnt==0 or N1==N0 -> out={~qm8,qm8,qm8?qm[7:0]:~qm[7:0]}, cnt+=qm8?(N1-N0):(N0-N1).
REQ-023 Else if (cnt>0 and N1>N0) or (cnt<0 and N0>N1) -> out={1,qm8,~qm[7:0]}, cnt+=2*qm8+(N0-N1).
REQ-024 Else -> out={0,qm8,qm[7:0]}, cnt+=(N1-N0)-2*(~qm8).
REQ-025 video_active_out SHALL be registered alongside tmds_out and be 1 exactly for data words.

Reset
REQ-026 rst_n_in low SHALL immediately clear: tmds_out=1101010100, video_active_out=0, err_short_blank_out=0, cnt=0, FSM=CTRL, all delay-line stages to {data 0, de 0, ctrl 00}.
REQ-027 Reset mid-VIDEO SHALL abort the period; after release, output SHALL be 1101010100 until new inputs emerge 11 cycles later, and the next video period SHALL require the full preamble sequence.

Verification
REQ-028 Reset, de_in=0, ctrl_in=2'b10 held -> tmds_out=1101010100 for 11 cycles, then 0101010100.
REQ-029 CHANNEL=1, 20 blank cycles, then de_in=1 at edge k -> 0010101011 edges k+1..k+8, 0100110011 at k+9,k+10, video_active_out=1 from k+11.
REQ-030 Three 0x00 pixels from cnt=0 -> 0100000000, 1111111111, 0100000000; cnt -8, +2, -6.
REQ-031 Blank of 4 cycles between two video periods -> no preamble/guard for second period, err_short_blank_out one pulse, data words continuous DC-balanced.
REQ-032 rst_n_in low for 1 cycle mid-VIDEO, asynchronous to clock edge -> outputs at reset values before next edge; recovery per REQ-027.
